md_hilo_sched: RTL

//  Sequences the EXE-stage multiplier and divider and owns the HI/LO registers.

---
 rtl/md_hilo_sched_if.sv | 48 ++++
 rtl/md_hilo_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/md_hilo_sched_if.sv
// ID-side op bus, multiplier/divider handshake and HI/LO outputs of md_hilo_sched.
// slave = the scheduler, master = the surrounding pipeline/units.
interface md_hilo_sched_if #(
    parameter int unsigned DW = 32
);
    logic          md_valid;
    logic [2:0]    md_op;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;

    logic          multbusy;
    logic          multover;
    logic [DW-1:0] mul_hi;
    logic [DW-1:0] mul_lo;

    logic          divbusy;
    logic          divover;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_r;

    logic          mult_start;
    logic          div_start;
    logic          md_signed;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          MDPause;
    logic          md_busy;
    logic          md_err;
    logic          md_divz;

    modport slave (
        input  md_valid, md_op, rs_data, rt_data,
               multbusy, multover, mul_hi, mul_lo,
               divbusy, divover, div_q, div_r,
        output mult_start, div_start, md_signed, op_a, op_b,
               hi_q, lo_q, MDPause, md_busy, md_err, md_divz
    );

    modport master (
        output md_valid, md_op, rs_data, rt_data,
               multbusy, multover, mul_hi, mul_lo,
               divbusy, divover, div_q, div_r,
        input  mult_start, div_start, md_signed, op_a, op_b,
               hi_q, lo_q, MDPause, md_busy, md_err, md_divz
    );
endinterface

// File: rtl/md_hilo_sched.sv
// HI/LO owner and multiplier/divider sequencer for the EXE stage.
// Optional MD_DIVZERO_EN: divide-by-zero is resolved locally instead of issued.
module md_hilo_sched #(
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           clrn,
    md_hilo_sched_if.slave bus
);
    localparam int unsigned   CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DW-1:0] hi_r, hi_nx;
    logic [DW-1:0] lo_r, lo_nx;
    logic [DW-1:0] op_a_r, op_b_r;
    logic          signed_r, signed_nx;
    logic          load_ops;
    logic          mult_start_r, mult_start_nx;
    logic          div_start_r, div_start_nx;
    logic          err_r, err_nx;
    logic          divz_r, divz_nx;
    logic          busy_r;
    logic          rt_zero;
    logic          unused_status;

`ifdef MD_DIVZERO_EN
    assign rt_zero = (bus.rt_data == '0);
`else
    assign rt_zero = 1'b0;
`endif

    // Busy strobes from the units are informational; sequencing uses only the over strobes.
    assign unused_status = bus.multbusy ^ bus.divbusy;

    // Next-state, HI/LO commit and issue decisions.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        hi_nx         = hi_r;
        lo_nx         = lo_r;
        signed_nx     = signed_r;
        load_ops      = 1'b0;
        mult_start_nx = 1'b0;
        div_start_nx  = 1'b0;
        err_nx        = err_r;
        divz_nx       = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.md_valid) begin
                    case (bus.md_op)
                        OP_MULT, OP_MULTU: begin
                            load_ops      = 1'b1;
                            signed_nx     = (bus.md_op == OP_MULT);
                            mult_start_nx = 1'b1;
                            cnt_nx        = '0;
                            err_nx        = 1'b0;
                            state_nx      = S_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            load_ops  = 1'b1;
                            signed_nx = (bus.md_op == OP_DIV);
                            if (rt_zero) begin
                                hi_nx   = bus.rs_data;
                                lo_nx   = '1;
                                divz_nx = 1'b1;
                            end else begin
                                div_start_nx = 1'b1;
                                cnt_nx       = '0;
                                err_nx       = 1'b0;
                                state_nx     = S_DIV_WAIT;
                            end
                        end
                        OP_MTHI: hi_nx = bus.rs_data;
                        OP_MTLO: lo_nx = bus.rs_data;
                        default: ;
                    endcase
                end
            end
            S_MUL_WAIT: begin
                cnt_nx = cnt + CW'(1);
                // The strobe seen alongside our own start pulse belongs to no issued op.
                if (bus.multover && !mult_start_r) begin
                    hi_nx    = bus.mul_hi;
                    lo_nx    = bus.mul_lo;
                    state_nx = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DIV_WAIT: begin
                cnt_nx = cnt + CW'(1);
                if (bus.divover && !div_start_r) begin
                    hi_nx    = bus.div_r;
                    lo_nx    = bus.div_q;
                    state_nx = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            hi_r         <= '0;
            lo_r         <= '0;
            op_a_r       <= '0;
            op_b_r       <= '0;
            signed_r     <= 1'b0;
            mult_start_r <= 1'b0;
            div_start_r  <= 1'b0;
            err_r        <= 1'b0;
            divz_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            hi_r         <= hi_nx;
            lo_r         <= lo_nx;
            signed_r     <= signed_nx;
            mult_start_r <= mult_start_nx;
            div_start_r  <= div_start_nx;
            err_r        <= err_nx;
            divz_r       <= divz_nx;
            busy_r       <= (state_nx != S_IDLE);
            if (load_ops) begin
                op_a_r <= bus.rs_data;
                op_b_r <= bus.rt_data;
            end
        end
    end

    assign bus.mult_start = mult_start_r;
    assign bus.div_start  = div_start_r;
    assign bus.md_signed  = signed_r;
    assign bus.op_a       = op_a_r;
    assign bus.op_b       = op_b_r;
    assign bus.hi_q       = hi_r;
    assign bus.lo_q       = lo_r;
    assign bus.md_busy    = busy_r;
    assign bus.md_err     = err_r;
    assign bus.md_divz    = divz_r;

    // Any HI/LO-class op must wait while a result is outstanding (RAW and WAW on HI/LO).
    assign bus.MDPause    = bus.md_valid && (state != S_IDLE);

endmodule
